// File: rtl/xor_hash_pkg.sv
// Shared definitions for the XOR-hash table write path: op encodings,
// record layout helpers and the default-geometry pipeline slot.
package xor_hash_pkg;

  localparam logic [1:0] OPT_READ   = 2'b00;
  localparam logic [1:0] OPT_WRITE  = 2'b01;
  localparam logic [1:0] OPT_RSVD   = 2'b10;
  localparam logic [1:0] OPT_DELETE = 2'b11;

  localparam int DEF_INDEX_WIDTH = 12;
  localparam int DEF_KEY_WIDTH   = 32;
  localparam int DEF_VALUE_WIDTH = 31;
  localparam int DEF_DATA_WIDTH  = 64;

  // Record layout: {zeros, live, value, key} with the key in the low bits.
  function automatic int rec_key_lsb();
    return 0;
  endfunction

  function automatic int rec_value_lsb(input int key_width);
    return key_width;
  endfunction

  function automatic int rec_live_bit(input int key_width, input int value_width);
    return key_width + value_width;
  endfunction

  function automatic logic is_table_write(input logic [1:0] opt);
    logic w;
    w = 1'b0;
    case (opt)
      OPT_WRITE, OPT_DELETE: w = 1'b1;
      OPT_READ, OPT_RSVD:    w = 1'b0;
    endcase
    return w;
  endfunction

  typedef struct packed {
    logic                       valid;
    logic [DEF_INDEX_WIDTH-1:0] index;
    logic [DEF_DATA_WIDTH-1:0]  record;
  } slot_t;

endpackage

// File: rtl/xor_reduce_bank.sv
// Combinational XOR of NUM_WR words packed side by side, word 0 in the low bits.
module xor_reduce_bank #(
  parameter int NUM_WR     = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic [NUM_WR*DATA_WIDTH-1:0] words_i,
  output logic [DATA_WIDTH-1:0]        xor_o
);

  always_comb begin
    xor_o = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      xor_o = xor_o ^ words_i[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/xor_write_pipe.sv
// Write-path pipeline from the XOR hash to the table banks with an index-hazard stall.
// Optional stall/write counters are built when XOR_WRITE_PIPE_STATS_EN is defined.
module xor_write_pipe
  import xor_hash_pkg::*;
#(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 31,
  parameter int DATA_WIDTH  = 64,
  parameter int PRE_STAGES  = 2,
  parameter int RD_LAT      = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [1:0]                               in_opt,
  input  logic [INDEX_WIDTH-1:0]                   in_index,
  input  logic [KEY_WIDTH-1:0]                     in_key,
  input  logic [VALUE_WIDTH-1:0]                   in_value,
  output logic                                     rd_valid,
  output logic [INDEX_WIDTH-1:0]                   rd_index,
  input  logic [NUM_MUL*(NUM_WR-1)*DATA_WIDTH-1:0] rd_other,
  output logic                                     wr_valid,
  output logic [INDEX_WIDTH-1:0]                   wr_index,
  output logic [NUM_MUL*DATA_WIDTH-1:0]            wr_data
`ifdef XOR_WRITE_PIPE_STATS_EN
  ,
  output logic [31:0]                              stall_count,
  output logic [31:0]                              write_count
`endif
);

  localparam int D         = PRE_STAGES + 1 + RD_LAT;
  localparam int NOTHER    = NUM_WR - 1;
  localparam int KEY_LSB   = rec_key_lsb();
  localparam int VAL_LSB   = rec_value_lsb(KEY_WIDTH);
  localparam int LIVE_BIT  = rec_live_bit(KEY_WIDTH, VALUE_WIDTH);

  typedef struct packed {
    logic                   valid;
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  record;
  } pipe_slot_t;

  pipe_slot_t     slot_q [D];
  pipe_slot_t     slot_in_d;
  pipe_slot_t     ret_slot;
  logic [D-1:0]   hit;
  logic           op_is_write;
  logic           stall;
  logic           accept_wr;

  genvar gi;

  // The match spans every slot including the one retiring this cycle, so a
  // same-index op waits until the write has actually left the pipe.
  generate
    for (gi = 0; gi < D; gi++) begin : g_hit
      assign hit[gi] = slot_q[gi].valid && (slot_q[gi].index == in_index);
    end
  endgenerate

  assign op_is_write = is_table_write(in_opt);
  assign stall       = in_valid && op_is_write && (|hit);
  assign in_ready    = !stall;
  assign accept_wr   = in_valid && op_is_write && !stall;

  always_comb begin
    slot_in_d = '0;
    if (accept_wr) begin
      slot_in_d.valid                            = 1'b1;
      slot_in_d.index                            = in_index;
      slot_in_d.record[KEY_LSB +: KEY_WIDTH]     = in_key;
      slot_in_d.record[VAL_LSB +: VALUE_WIDTH]   = in_value;
      slot_in_d.record[LIVE_BIT]                 = ~in_opt[1];
    end
  end

  // Reads, reserved ops and stalled cycles all enter as all-zero bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= slot_in_d;
      for (int i = 1; i < D; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  assign rd_valid = slot_q[PRE_STAGES].valid;
  assign rd_index = slot_q[PRE_STAGES].index;

  assign ret_slot = slot_q[D-1];
  assign wr_valid = ret_slot.valid;
  assign wr_index = ret_slot.index;

  generate
    for (gi = 0; gi < NUM_MUL; gi++) begin : g_bank
      logic [NUM_WR*DATA_WIDTH-1:0] words;
      logic [DATA_WIDTH-1:0]        xored;

      assign words = {rd_other[gi*NOTHER*DATA_WIDTH +: NOTHER*DATA_WIDTH], ret_slot.record};

      xor_reduce_bank #(
        .NUM_WR     (NUM_WR),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_xor (
        .words_i (words),
        .xor_o   (xored)
      );

      // Bubbles present zero so the bus stays quiet between writes.
      assign wr_data[gi*DATA_WIDTH +: DATA_WIDTH] = ret_slot.valid ? xored : '0;
    end
  endgenerate

`ifdef XOR_WRITE_PIPE_STATS_EN
  logic [31:0] stall_count_q;
  logic [31:0] write_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      write_count_q <= '0;
    end else begin
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (ret_slot.valid) begin
        write_count_q <= write_count_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_xor_write_pipe.sv
// Self-checking bench for xor_write_pipe: directed scenarios plus random traffic
// compared against a cycle-count model of accepted ops.
module tb_xor_write_pipe;
  import xor_hash_pkg::*;

  localparam int P   = 2;
  localparam int R   = 2;
  localparam int D   = P + 1 + R;
  localparam int NM  = 4;
  localparam int NW  = 8;
  localparam int DW  = 64;
  localparam int OW  = NM * (NW - 1) * DW;
  localparam int SOW = 1 * (NW - 1) * DW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     in_opt = 2'b00;
  logic [11:0]    in_index = '0;
  logic [31:0]    in_key = '0;
  logic [30:0]    in_value = '0;
  logic           rd_valid;
  logic [11:0]    rd_index;
  logic [OW-1:0]  rd_other = '0;
  logic           wr_valid;
  logic [11:0]    wr_index;
  logic [NM*DW-1:0] wr_data;

  logic           s_in_valid = 1'b0;
  logic           s_in_ready;
  logic [1:0]     s_in_opt = 2'b00;
  logic [11:0]    s_in_index = '0;
  logic [31:0]    s_in_key = '0;
  logic [30:0]    s_in_value = '0;
  logic           s_rd_valid;
  logic [11:0]    s_rd_index;
  logic [SOW-1:0] s_rd_other = '0;
  logic           s_wr_valid;
  logic [11:0]    s_wr_index;
  logic [DW-1:0]  s_wr_data;

`ifdef XOR_WRITE_PIPE_STATS_EN
  logic [31:0] stall_count, write_count, s_stall_count, s_write_count;
`endif

  always #5 clk = ~clk;

  xor_write_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opt(in_opt), .in_index(in_index), .in_key(in_key), .in_value(in_value),
    .rd_valid(rd_valid), .rd_index(rd_index), .rd_other(rd_other),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data)
`ifdef XOR_WRITE_PIPE_STATS_EN
    , .stall_count(stall_count), .write_count(write_count)
`endif
  );

  xor_write_pipe #(.NUM_MUL(1), .PRE_STAGES(0), .RD_LAT(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_opt(s_in_opt), .in_index(s_in_index), .in_key(s_in_key), .in_value(s_in_value),
    .rd_valid(s_rd_valid), .rd_index(s_rd_index), .rd_other(s_rd_other),
    .wr_valid(s_wr_valid), .wr_index(s_wr_index), .wr_data(s_wr_data)
`ifdef XOR_WRITE_PIPE_STATS_EN
    , .stall_count(s_stall_count), .write_count(s_write_count)
`endif
  );

  typedef struct packed {
    logic           ready;
    logic           rdv;
    logic [11:0]    rdi;
    logic           wrv;
    logic [11:0]    wri;
    logic [NM*DW-1:0] wrd;
  } obs_t;

  typedef struct {
    int          acc;
    logic [11:0] idx;
    logic [63:0] rec;
  } op_t;

  op_t pend[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  logic [OW-1:0] zero_oth = '0;

  function automatic logic [63:0] mkrec(input logic [1:0] opt, input logic [31:0] key,
                                        input logic [30:0] val);
    return {~opt[1], val, key};
  endfunction

  // One clock of the main DUT: drive, then predict from the list of accepted ops.
  task automatic run_cycle(input logic v, input logic [1:0] opt, input logic [11:0] idx,
                           input logic [31:0] key, input logic [30:0] val,
                           input logic [OW-1:0] oth, output obs_t e, output obs_t o);
    logic [63:0] acc;
    @(posedge clk); #1;
    cyc++;
    in_valid = v; in_opt = opt; in_index = idx; in_key = key; in_value = val;
    rd_other = oth;
    #1;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].acc + D < cyc) pend.delete(i);
    e = '0;
    e.ready = 1'b1;
    foreach (pend[i]) begin
      if (v && opt[0] && pend[i].idx == idx && cyc >= pend[i].acc + 1 && cyc <= pend[i].acc + D)
        e.ready = 1'b0;
      if (pend[i].acc + P + 1 == cyc) begin
        e.rdv = 1'b1;
        e.rdi = pend[i].idx;
      end
      if (pend[i].acc + D == cyc) begin
        e.wrv = 1'b1;
        e.wri = pend[i].idx;
        for (int b = 0; b < NM; b++) begin
          acc = pend[i].rec;
          for (int w = 0; w < NW - 1; w++) acc = acc ^ oth[(b*(NW-1)+w)*DW +: DW];
          e.wrd[b*DW +: DW] = acc;
        end
      end
    end
    o.ready = in_ready; o.rdv = rd_valid; o.rdi = rd_index;
    o.wrv = wr_valid; o.wri = wr_index; o.wrd = wr_data;
    if (v && opt[0] && e.ready) pend.push_back('{cyc, idx, mkrec(opt, key, val)});
    $display("[TB] cyc %0d v=%b opt=%b idx=%h ready=%b rd=%b/%h wr=%b/%h", cyc, v, opt, idx,
             o.ready, o.rdv, o.rdi, o.wrv, o.wri);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    reset = 1'b1; in_valid = 1'b0; s_in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      cyc++;
    end
    reset = 1'b0;
    pend.delete();
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; in_opt = OPT_WRITE; in_index = 12'h00A;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    tests++; if (rd_index !== 12'h0) begin fails++; $display("FAIL reset_rd_index got %h want 0", rd_index); end
    tests++; if (wr_index !== 12'h0) begin fails++; $display("FAIL reset_wr_index got %h want 0", wr_index); end
    tests++; if (wr_data !== '0) begin fails++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_single_write();
    obs_t e, o;
    logic [NM*DW-1:0] exp_wd;
    exp_wd = {NM{64'h80000001_12345678}};
    run_cycle(1'b1, OPT_WRITE, 12'h00A, 32'h12345678, 31'h1, zero_oth, e, o);
    tests++; if (o.ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", o.ready); end
    for (int k = 1; k <= 6; k++) begin
      run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, zero_oth, e, o);
      tests++; if (o.rdv !== (k == 3)) begin fails++; $display("FAIL single_rd_valid k=%0d got %b", k, o.rdv); end
      tests++; if (o.wrv !== (k == 5)) begin fails++; $display("FAIL single_wr_valid k=%0d got %b", k, o.wrv); end
      if (k == 3) begin
        tests++; if (o.rdi !== 12'h00A) begin fails++; $display("FAIL single_rd_index got %h want 00a", o.rdi); end
      end
      if (k == 5) begin
        tests++; if (o.wri !== 12'h00A) begin fails++; $display("FAIL single_wr_index got %h want 00a", o.wri); end
        tests++; if (o.wrd !== exp_wd) begin fails++; $display("FAIL single_wr_data got %h want %h", o.wrd, exp_wd); end
      end
    end
  endtask

  task automatic test_delete();
    obs_t e, o;
    logic [OW-1:0] oth;
    logic [63:0] rec;
    logic [NM*DW-1:0] exp_wd;
    oth = '0;
    oth[(1*(NW-1)+0)*DW +: DW] = 64'h1;
    oth[(1*(NW-1)+1)*DW +: DW] = 64'h2;
    oth[(1*(NW-1)+2)*DW +: DW] = 64'h4;
    rec = {1'b0, 31'h2A, 32'hCAFE0001};
    exp_wd = {rec, rec, rec ^ 64'h7, rec};
    run_cycle(1'b1, OPT_DELETE, 12'h123, 32'hCAFE0001, 31'h2A, oth, e, o);
    tests++; if (o.ready !== 1'b1) begin fails++; $display("FAIL delete_ready got %b want 1", o.ready); end
    for (int k = 1; k <= 6; k++) begin
      run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, oth, e, o);
      tests++; if (o.wrv !== (k == 5)) begin fails++; $display("FAIL delete_wr_valid k=%0d got %b", k, o.wrv); end
      if (k == 5) begin
        tests++; if (o.wrd !== exp_wd) begin fails++; $display("FAIL delete_wr_data got %h want %h", o.wrd, exp_wd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [63:0] rec_b;
    rec_b = {1'b1, 31'h0BEEF, 32'hB0B0B0B0};
    run_cycle(1'b1, OPT_WRITE, 12'h005, 32'hA0A0A0A0, 31'h1111, zero_oth, e, o);
    for (int k = 1; k <= 12; k++) begin
      if (k <= 6) run_cycle(1'b1, OPT_WRITE, 12'h005, 32'hB0B0B0B0, 31'h0BEEF, zero_oth, e, o);
      else        run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, zero_oth, e, o);
      if (k <= 6) begin
        tests++; if (o.ready !== (k == 6)) begin fails++; $display("FAIL b2b_ready k=%0d got %b", k, o.ready); end
      end
      tests++; if (o.wrv !== (k == 5 || k == 11)) begin fails++; $display("FAIL b2b_wr_valid k=%0d got %b", k, o.wrv); end
      if (k == 11) begin
        tests++; if (o.wrd[63:0] !== rec_b) begin fails++; $display("FAIL b2b_wr_data got %h want %h", o.wrd[63:0], rec_b); end
      end
    end
  endtask

  task automatic test_read_passthrough();
    obs_t e, o;
    run_cycle(1'b1, OPT_WRITE, 12'h005, 32'h55, 31'h5, zero_oth, e, o);
    for (int k = 1; k <= 7; k++) begin
      if (k == 1)      run_cycle(1'b1, OPT_READ, 12'h005, 32'h66, 31'h6, zero_oth, e, o);
      else if (k == 2) run_cycle(1'b1, OPT_RSVD, 12'h005, 32'h77, 31'h7, zero_oth, e, o);
      else             run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, zero_oth, e, o);
      if (k <= 2) begin
        tests++; if (o.ready !== 1'b1) begin fails++; $display("FAIL read_ready k=%0d got %b want 1", k, o.ready); end
      end
      tests++; if (o.rdv !== (k == 3)) begin fails++; $display("FAIL read_rd_valid k=%0d got %b", k, o.rdv); end
      tests++; if (o.wrv !== (k == 5)) begin fails++; $display("FAIL read_wr_valid k=%0d got %b", k, o.wrv); end
    end
  endtask

  task automatic test_reset_midflight();
    obs_t e, o;
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, OPT_WRITE, 12'(k + 1), 32'(k), 31'(k), zero_oth, e, o);
      tests++; if (o.ready !== 1'b1) begin fails++; $display("FAIL midrst_accept k=%0d got %b", k, o.ready); end
    end
    do_reset();
    in_valid = 1'b1; in_opt = OPT_WRITE; in_index = 12'h003;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, zero_oth, e, o);
      tests++; if (o.wrv !== 1'b0) begin fails++; $display("FAIL midrst_wr_valid k=%0d got %b want 0", k, o.wrv); end
      tests++; if (o.rdv !== 1'b0) begin fails++; $display("FAIL midrst_rd_valid k=%0d got %b want 0", k, o.rdv); end
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    logic [OW-1:0] oth;
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < OW / 32; j++) oth[j*32 +: 32] = $urandom();
      if (n < 294)
        run_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 3)),
                  $urandom(), 31'($urandom()), oth, e, o);
      else
        run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, oth, e, o);
      tests++; if (o.ready !== e.ready) begin fails++; $display("FAIL rand_ready n=%0d got %b want %b", n, o.ready, e.ready); end
      tests++; if (o.rdv !== e.rdv) begin fails++; $display("FAIL rand_rd_valid n=%0d got %b want %b", n, o.rdv, e.rdv); end
      tests++; if (o.wrv !== e.wrv) begin fails++; $display("FAIL rand_wr_valid n=%0d got %b want %b", n, o.wrv, e.wrv); end
      if (e.rdv) begin
        tests++; if (o.rdi !== e.rdi) begin fails++; $display("FAIL rand_rd_index n=%0d got %h want %h", n, o.rdi, e.rdi); end
      end
      if (e.wrv) begin
        tests++; if (o.wri !== e.wri) begin fails++; $display("FAIL rand_wr_index n=%0d got %h want %h", n, o.wri, e.wri); end
        tests++; if (o.wrd !== e.wrd) begin fails++; $display("FAIL rand_wr_data n=%0d got %h want %h", n, o.wrd, e.wrd); end
      end
    end
  endtask

`ifdef XOR_WRITE_PIPE_STATS_EN
  task automatic test_stats();
    obs_t e, o;
    do_reset();
    #1;
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL stats_reset_stall got %0d want 0", stall_count); end
    tests++; if (write_count !== 32'd0) begin fails++; $display("FAIL stats_reset_write got %0d want 0", write_count); end
    run_cycle(1'b1, OPT_WRITE, 12'h009, 32'h9, 31'h9, zero_oth, e, o);
    for (int k = 1; k <= 12; k++) begin
      if (k >= 2 && k <= 6) run_cycle(1'b1, OPT_WRITE, 12'h009, 32'h19, 31'h19, zero_oth, e, o);
      else                  run_cycle(1'b0, OPT_READ, 12'h0, 32'h0, 31'h0, zero_oth, e, o);
      if (k == 7) begin
        tests++; if (stall_count !== 32'd4) begin fails++; $display("FAIL stats_stall got %0d want 4", stall_count); end
        tests++; if (write_count !== 32'd1) begin fails++; $display("FAIL stats_write got %0d want 1", write_count); end
      end
    end
  endtask
`endif

  task automatic test_small_config();
    logic [11:0] idx;
    logic [31:0] key;
    logic [30:0] val;
    logic [63:0] exp_d;
    for (int t = 0; t < 4; t++) begin
      idx = 12'($urandom()); key = $urandom(); val = 31'($urandom());
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_in_opt = (t % 2 == 0) ? OPT_WRITE : OPT_DELETE;
      s_in_index = idx; s_in_key = key; s_in_value = val;
      #1;
      tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL small_ready0 t=%0d got %b want 1", t, s_in_ready); end
      @(posedge clk); #1;
      s_in_opt = OPT_WRITE; s_in_key = ~key;
      #1;
      tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL small_stall1 t=%0d got %b want 0", t, s_in_ready); end
      tests++; if (s_rd_valid !== 1'b1 || s_rd_index !== idx) begin fails++; $display("FAIL small_rd t=%0d got %b/%h want 1/%h", t, s_rd_valid, s_rd_index, idx); end
      tests++; if (s_wr_valid !== 1'b0) begin fails++; $display("FAIL small_early_wr t=%0d got %b want 0", t, s_wr_valid); end
      @(posedge clk); #1;
      for (int j = 0; j < SOW / 32; j++) s_rd_other[j*32 +: 32] = $urandom();
      exp_d = {(t % 2 == 0), val, key};
      for (int w = 0; w < NW - 1; w++) exp_d = exp_d ^ s_rd_other[w*DW +: DW];
      #1;
      tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL small_stall2 t=%0d got %b want 0", t, s_in_ready); end
      tests++; if (s_wr_valid !== 1'b1 || s_wr_index !== idx) begin fails++; $display("FAIL small_wr t=%0d got %b/%h want 1/%h", t, s_wr_valid, s_wr_index, idx); end
      tests++; if (s_wr_data !== exp_d) begin fails++; $display("FAIL small_wr_data t=%0d got %h want %h", t, s_wr_data, exp_d); end
      s_in_valid = 1'b0;
      @(posedge clk); #2;
      tests++; if (s_wr_valid !== 1'b0 || s_rd_valid !== 1'b0) begin fails++; $display("FAIL small_idle t=%0d got %b/%b want 0/0", t, s_rd_valid, s_wr_valid); end
      $display("[TB] small trial %0d idx=%h wr_data=%h", t, idx, s_wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_delete();
    test_back_to_back();
    test_read_passthrough();
    test_reset_midflight();
    test_random();
`ifdef XOR_WRITE_PIPE_STATS_EN
    test_stats();
`endif
    test_small_config();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
